led_level_meter: RTL and testbench

- Parametrised successor to the 8-LED log2 level display.
- Takes offset-binary audio samples with a valid strobe and computes signed magnitude about mid-scale.
- Drives an N-LED log2 bar or dot display with peak-hold, timed peak decay and a clip indicator.
- Sits between the ADC sample path (dclk domain, 44.1 kHz) and the board LEDs.

---
 rtl/led_level_meter.sv | 168 ++++++++++++++++
 tb/tb_led_level_meter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/led_level_meter.sv
// -----------------------------------------------------------------------------
// led_level_meter
//
// Log2 LED level meter for offset-binary audio samples. Each valid sample is
// folded to a magnitude about mid-scale. The top NLEDS magnitude bits are
// priority-encoded into a level from 0 to NLEDS, which drives either a bar
// display or a dot display. A peak marker is held for HOLD_CYCLES and then
// decays one LED every DECAY_CYCLES. It never drops below the current level.
// A full-scale sample lights the clip indicator for HOLD_CYCLES.
//
// Ports
//   dclk       sample clock; all state updates on its rising edge
//   rst        asynchronous, active-high reset
//   din        offset-binary sample (mid-scale = 2^(DW-1))
//   din_valid  din is captured on an edge where this is 1
//   dot_mode   0 = bar display, 1 = dot display (applied at the leds register)
//   leds       registered LED drive
//   peak_out   registered current peak level (0..NLEDS)
//   clip       registered clip indicator
// -----------------------------------------------------------------------------
module led_level_meter #(
  parameter int unsigned DW           = 12,
  parameter int unsigned NLEDS        = 8,
  parameter int unsigned HOLD_CYCLES  = 44100,
  parameter int unsigned DECAY_CYCLES = 4410
) (
  input  logic                             dclk,
  input  logic                             rst,
  input  logic [DW-1:0]                    din,
  input  logic                             din_valid,
  input  logic                             dot_mode,
  output logic [NLEDS-1:0]                 leds,
  output logic [$clog2(NLEDS+1)-1:0]       peak_out,
  output logic                             clip
);

  localparam int unsigned PW  = $clog2(NLEDS + 1);
  localparam int unsigned HW  = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned DCW = $clog2(DECAY_CYCLES + 1);

  localparam logic [HW-1:0]  HOLD_INIT  = HW'(HOLD_CYCLES - 1);
  localparam logic [DCW-1:0] DECAY_INIT = DCW'(DECAY_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PW-1:0]    level_q,     level_d;
  logic [PW-1:0]    peak_q,      peak_d;
  logic [HW-1:0]    hold_cnt_q,  hold_cnt_d;
  logic [DCW-1:0]   decay_cnt_q, decay_cnt_d;
  logic [HW-1:0]    clip_cnt_q,  clip_cnt_d;
  logic             clip_q,      clip_d;
  logic [NLEDS-1:0] leds_q,      leds_d;

  // ---------------------------------------------------------------------------
  // Magnitude and level
  // ---------------------------------------------------------------------------
  logic [DW-2:0]    mag;
  logic [NLEDS-1:0] win;
  logic [PW-1:0]    new_level;
  logic             clip_hit;

  // Below mid-scale, 2^(DW-1)-1-din equals the bitwise inverse of the low bits.
  // At or above mid-scale, din-2^(DW-1) equals the low bits unchanged.
  always_comb begin
    mag = din[DW-1] ? din[DW-2:0] : ~din[DW-2:0];
  end

  assign win      = mag[DW-2 -: NLEDS];
  assign clip_hit = &mag;

  // Priority encoder. The highest set bit is written last, so it wins.
  always_comb begin
    new_level = '0;
    for (int unsigned i = 0; i < NLEDS; i++) begin
      if (win[i]) begin
        new_level = PW'(i + 1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Level capture, peak hold/decay, clip
  // ---------------------------------------------------------------------------
  always_comb begin
    level_d     = level_q;
    peak_d      = peak_q;
    hold_cnt_d  = hold_cnt_q;
    decay_cnt_d = decay_cnt_q;
    clip_d      = clip_q;
    clip_cnt_d  = clip_cnt_q;

    if (din_valid) begin
      level_d = new_level;
    end

    // Compare against the level that is already registered. A sample landing
    // on this edge raises the peak through the first branch.
    if (din_valid && (new_level >= peak_q)) begin
      peak_d      = new_level;
      hold_cnt_d  = HOLD_INIT;
      decay_cnt_d = DECAY_INIT;
    end else if (hold_cnt_q != '0) begin
      hold_cnt_d = hold_cnt_q - HW'(1);
    end else if (peak_q > level_q) begin
      if (decay_cnt_q == '0) begin
        peak_d      = peak_q - PW'(1);
        decay_cnt_d = DECAY_INIT;
      end else begin
        decay_cnt_d = decay_cnt_q - DCW'(1);
      end
    end

    if (din_valid && clip_hit) begin
      clip_d     = 1'b1;
      clip_cnt_d = HOLD_INIT;
    end else if (clip_cnt_q != '0) begin
      clip_cnt_d = clip_cnt_q - HW'(1);
    end else begin
      clip_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // LED mapping, built from the registered level and peak
  // ---------------------------------------------------------------------------
  always_comb begin
    leds_d = '0;
    for (int unsigned i = 0; i < NLEDS; i++) begin
      if (dot_mode) begin
        leds_d[i] = (PW'(i + 1) == level_q);
      end else begin
        leds_d[i] = (PW'(i) < level_q);
      end
      if (PW'(i + 1) == peak_q) begin
        leds_d[i] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      level_q     <= '0;
      peak_q      <= '0;
      hold_cnt_q  <= '0;
      decay_cnt_q <= '0;
      clip_q      <= 1'b0;
      clip_cnt_q  <= '0;
      leds_q      <= '0;
    end else begin
      level_q     <= level_d;
      peak_q      <= peak_d;
      hold_cnt_q  <= hold_cnt_d;
      decay_cnt_q <= decay_cnt_d;
      clip_q      <= clip_d;
      clip_cnt_q  <= clip_cnt_d;
      leds_q      <= leds_d;
    end
  end

  assign leds     = leds_q;
  assign peak_out = peak_q;
  assign clip     = clip_q;

endmodule

// File: tb/tb_led_level_meter.sv
// -----------------------------------------------------------------------------
// tb_led_level_meter
//
// Directed bench for led_level_meter with DW=12, NLEDS=8, HOLD_CYCLES=4 and
// DECAY_CYCLES=2. Inputs change 1 ns after a rising edge. Outputs are sampled
// at the same point.
// -----------------------------------------------------------------------------
module tb_led_level_meter;

  localparam int unsigned DW = 12;
  localparam int unsigned NL = 8;

  logic          dclk = 1'b0;
  logic          rst;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          dot_mode;
  logic [NL-1:0] leds;
  logic [3:0]    peak_out;
  logic          clip;

  int n_cmp  = 0;
  int n_fail = 0;

  led_level_meter #(
    .DW          (DW),
    .NLEDS       (NL),
    .HOLD_CYCLES (4),
    .DECAY_CYCLES(2)
  ) dut (
    .dclk     (dclk),
    .rst      (rst),
    .din      (din),
    .din_valid(din_valid),
    .dot_mode (dot_mode),
    .leds     (leds),
    .peak_out (peak_out),
    .clip     (clip)
  );

  always #5 dclk = ~dclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge dclk);
    #1;
  endtask

  // One valid sample captured on the next edge. On return, the time is 1 ns
  // past that edge and din_valid is low again.
  task automatic sample(input logic [DW-1:0] d);
    din       = d;
    din_valid = 1'b1;
    step(1);
    din_valid = 1'b0;
  endtask

  // Reset pulse placed between clock edges.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  logic [DW-1:0] lv_din  [5] = '{12'h800, 12'h820, 12'h808, 12'hC00, 12'h7DF};
  logic [7:0]    lv_leds [5] = '{8'h00,   8'h07,   8'h01,   8'hFF,   8'h07};
  logic [3:0]    lv_peak [5] = '{4'd0,    4'd3,    4'd1,    4'd8,    4'd3};
  // peak_out after edges E0+2 .. E0+16
  logic [3:0]    decay_exp [15] = '{4'd8, 4'd8, 4'd8, 4'd7, 4'd7, 4'd6, 4'd6,
                                    4'd5, 4'd5, 4'd4, 4'd4, 4'd3, 4'd3, 4'd3, 4'd3};

  initial begin
    rst       = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    dot_mode  = 1'b0;
    #2;
    check("reset_leds", 32'(leds), 32'h00);
    check("reset_peak", 32'(peak_out), 32'd0);
    check("reset_clip", 32'(clip), 32'd0);
    #10;
    rst = 1'b0;
    step(1);

    // Level map. Reset before each vector so that no earlier peak marker remains.
    for (int i = 0; i < 5; i++) begin
      do_reset();
      sample(lv_din[i]);
      check($sformatf("map_peak_%0d", i), 32'(peak_out), 32'(lv_peak[i]));
      step(1);
      check($sformatf("map_leds_%0d", i), 32'(leds), 32'(lv_leds[i]));
    end

    // din is ignored while din_valid is low.
    do_reset();
    din = 12'hC00;
    step(2);
    check("novalid_leds", 32'(leds), 32'h00);
    check("novalid_peak", 32'(peak_out), 32'd0);

    // Asynchronous reset in the middle of a cycle.
    do_reset();
    sample(12'hFFF);
    step(1);
    check("pre_rst_leds", 32'(leds), 32'hFF);
    check("pre_rst_clip", 32'(clip), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_leds", 32'(leds), 32'h00);
    check("async_rst_peak", 32'(peak_out), 32'd0);
    check("async_rst_clip", 32'(clip), 32'd0);
    #2;
    rst = 1'b0;
    step(1);
    check("post_rst_leds", 32'(leds), 32'h00);

    // Peak hold and decay.
    do_reset();
    sample(12'hC00);                     // E0
    check("pk_e0", 32'(peak_out), 32'd8);
    sample(12'h820);                     // E0+1
    check("pk_e1", 32'(peak_out), 32'd8);
    step(1);                             // E0+2
    check("pk_leds_87", 32'(leds), 32'h87);
    check("pk_e2", 32'(peak_out), 32'(decay_exp[0]));
    for (int k = 1; k < 15; k++) begin
      step(1);
      check($sformatf("pk_e%0d", k + 2), 32'(peak_out), 32'(decay_exp[k]));
    end
    step(1);
    check("pk_floor_leds", 32'(leds), 32'h07);

    // Dot mode, then a switch back to bar mode.
    do_reset();
    sample(12'hC00);
    sample(12'h820);
    dot_mode = 1'b1;
    step(1);
    check("dot_leds", 32'(leds), 32'h84);
    dot_mode = 1'b0;
    step(1);
    check("bar_again_leds", 32'(leds), 32'h87);

    // Hold refresh: a full-scale level every three edges keeps the peak at 8.
    do_reset();
    for (int r = 0; r < 6; r++) begin
      sample(12'hC00);
      check($sformatf("refresh_cap_%0d", r), 32'(peak_out), 32'd8);
      step(2);
      check($sformatf("refresh_gap_%0d", r), 32'(peak_out), 32'd8);
    end

    // Clip: set, then clear after the hold expires.
    do_reset();
    sample(12'h000);                     // E0
    check("clip_e0", 32'(clip), 32'd1);
    step(1);                             // E0+1
    check("clip_leds", 32'(leds), 32'hFF);
    check("clip_e1", 32'(clip), 32'd1);
    step(2);                             // E0+3
    check("clip_e3", 32'(clip), 32'd1);
    step(1);                             // E0+4
    check("clip_e4", 32'(clip), 32'd0);

    // Clip retrigger extends the hold.
    do_reset();
    sample(12'h000);                     // E0
    step(1);                             // E0+1
    sample(12'hFFF);                     // E0+2
    step(2);                             // E0+4
    check("clipx_e4", 32'(clip), 32'd1);
    step(1);                             // E0+5
    check("clipx_e5", 32'(clip), 32'd1);
    step(1);                             // E0+6
    check("clipx_e6", 32'(clip), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
